// File: rtl/psr_cond_unit_if.sv
// Bundle between the ALU / branch-control side (master) and the PSR +
// condition unit (slave). It carries the flag and PSR write ports, the
// condition request/response handshake and the status outputs.
//
// Condition handshake: the master raises cond_req with cond_code. The unit
// takes the request at the first rising edge where cond_req && cond_ready.
// The unit then holds cond_valid/cond_true stable until the edge where
// cond_ack is 1. A request is never queued, and cond_ack in idle is ignored.
interface psr_cond_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      alu_flags;
    logic             flag_we_cf;
    logic             flag_we_lnz;
    logic             psr_wr;
    logic [15:0]      psr_wdata;
    logic [15:0]      psr;
    logic             cond_req;
    logic [3:0]       cond_code;
    logic             cond_ready;
    logic             cond_valid;
    logic             cond_true;
    logic             cond_ack;
    logic [CNT_W-1:0] taken_count;
    logic             dbg_state;

    modport master (
        output alu_flags, flag_we_cf, flag_we_lnz, psr_wr, psr_wdata,
        output cond_req, cond_code, cond_ack,
        input  psr, cond_ready, cond_valid, cond_true, taken_count, dbg_state
    );

    modport slave (
        input  alu_flags, flag_we_cf, flag_we_lnz, psr_wr, psr_wdata,
        input  cond_req, cond_code, cond_ack,
        output psr, cond_ready, cond_valid, cond_true, taken_count, dbg_state
    );
endinterface

// File: rtl/psr_cond_unit.sv
// Processor status register plus CR16 condition evaluator. The PSR is loaded
// from ALU flag writes or from a software write. Condition codes are evaluated
// against the PSR and returned through a one-deep req/valid/ack handshake.
// A saturating counter counts the taken conditions.
module psr_cond_unit #(
    parameter bit BYPASS = 1'b0,
    parameter int CNT_W  = 16
) (
    input logic       clk,
    input logic       reset,
    psr_cond_if.slave bus
);
    localparam logic [15:0] PSR_MASK = 16'h00E5;
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_RESP   = 1'b1;

    logic [15:0]      psr_q, psr_d;
    logic [0:0]       state_q, state_d;
    logic             cond_true_q, cond_true_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      eval_psr;
    logic             eval_res;
    logic             accept;

    // Next PSR: a software write overrides flag loads; each flag enable touches only its own bits
    always_comb begin
        psr_d = psr_q;
        if (bus.psr_wr) begin
            psr_d = bus.psr_wdata & PSR_MASK;
        end else begin
            if (bus.flag_we_cf) begin
                psr_d[0] = bus.alu_flags[0];
                psr_d[5] = bus.alu_flags[5];
            end
            if (bus.flag_we_lnz) begin
                psr_d[2] = bus.alu_flags[2];
                psr_d[6] = bus.alu_flags[6];
                psr_d[7] = bus.alu_flags[7];
            end
        end
    end

    // Condition table over C=0, L=2, F=5, Z=6, N=7; bypass mode sees this cycle's flag writes
    always_comb begin
        eval_psr = BYPASS ? psr_d : psr_q;
        eval_res = 1'b0;
        case (bus.cond_code)
            4'b0000: eval_res =  eval_psr[6];
            4'b0001: eval_res = ~eval_psr[6];
            4'b0010: eval_res =  eval_psr[0];
            4'b0011: eval_res = ~eval_psr[0];
            4'b0100: eval_res =  eval_psr[2];
            4'b0101: eval_res = ~eval_psr[2];
            4'b0110: eval_res =  eval_psr[7];
            4'b0111: eval_res = ~eval_psr[7];
            4'b1000: eval_res =  eval_psr[5];
            4'b1001: eval_res = ~eval_psr[5];
            4'b1010: eval_res = ~eval_psr[2] & ~eval_psr[6];
            4'b1011: eval_res =  eval_psr[2] |  eval_psr[6];
            4'b1100: eval_res = ~eval_psr[7] & ~eval_psr[6];
            4'b1101: eval_res =  eval_psr[7] |  eval_psr[6];
            4'b1110: eval_res = 1'b1;
            default: eval_res = 1'b0;
        endcase
    end

    // Handshake FSM: accept only in IDLE, and leave RESP only on ack, so there is no same-cycle re-accept
    always_comb begin
        accept      = (state_q == S_IDLE) && bus.cond_req;
        state_d     = state_q;
        cond_true_d = cond_true_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_RESP;
                    cond_true_d = eval_res;
                    if (eval_res && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (bus.cond_ack) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers; the asynchronous reset discards any pending result at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_q       <= '0;
            state_q     <= S_IDLE;
            cond_true_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            psr_q       <= psr_d;
            state_q     <= state_d;
            cond_true_q <= cond_true_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.psr         = psr_q;
    assign bus.cond_ready  = (state_q == S_IDLE);
    assign bus.cond_valid  = (state_q == S_RESP);
    assign bus.cond_true   = cond_true_q;
    assign bus.taken_count = cnt_q;
    assign bus.dbg_state   = state_q[0];
endmodule

// File: tb/tb_psr_cond_unit.sv
// Directed bench for psr_cond_unit. Three instances receive the same stimulus:
// u0 uses the registered PSR, u1 uses bypass, and u2 has a 2-bit taken counter.
module tb_psr_cond_unit;
    logic        clk;
    logic        reset;
    logic [15:0] alu_flags;
    logic        flag_we_cf, flag_we_lnz, psr_wr;
    logic [15:0] psr_wdata;
    logic        cond_req, cond_ack;
    logic [3:0]  cond_code;

    int total;
    int bad;
    int cnt0, cnt1, cnt2;
    logic [15:0] exp_psr;

    psr_cond_if #(.CNT_W(16)) i0 ();
    psr_cond_if #(.CNT_W(16)) i1 ();
    psr_cond_if #(.CNT_W(2))  i2 ();

    assign i0.alu_flags = alu_flags;  assign i1.alu_flags = alu_flags;  assign i2.alu_flags = alu_flags;
    assign i0.flag_we_cf = flag_we_cf; assign i1.flag_we_cf = flag_we_cf; assign i2.flag_we_cf = flag_we_cf;
    assign i0.flag_we_lnz = flag_we_lnz; assign i1.flag_we_lnz = flag_we_lnz; assign i2.flag_we_lnz = flag_we_lnz;
    assign i0.psr_wr = psr_wr;        assign i1.psr_wr = psr_wr;        assign i2.psr_wr = psr_wr;
    assign i0.psr_wdata = psr_wdata;  assign i1.psr_wdata = psr_wdata;  assign i2.psr_wdata = psr_wdata;
    assign i0.cond_req = cond_req;    assign i1.cond_req = cond_req;    assign i2.cond_req = cond_req;
    assign i0.cond_code = cond_code;  assign i1.cond_code = cond_code;  assign i2.cond_code = cond_code;
    assign i0.cond_ack = cond_ack;    assign i1.cond_ack = cond_ack;    assign i2.cond_ack = cond_ack;

    psr_cond_unit #(.BYPASS(1'b0), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(i0.slave));
    psr_cond_unit #(.BYPASS(1'b1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
    psr_cond_unit #(.BYPASS(1'b0), .CNT_W(2))  u2 (.clk(clk), .reset(reset), .bus(i2.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_cnt0"}, 32'(i0.taken_count), 32'(cnt0));
        chk({tag, "_cnt1"}, 32'(i1.taken_count), 32'(cnt1));
        chk({tag, "_cnt2"}, 32'(i2.taken_count), 32'(cnt2));
    endtask

    task automatic chk_psr(input string tag);
        chk({tag, "_psr0"}, 32'(i0.psr), 32'(exp_psr));
        chk({tag, "_psr1"}, 32'(i1.psr), 32'(exp_psr));
        chk({tag, "_psr2"}, 32'(i2.psr), 32'(exp_psr));
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ready"}, 32'(i0.cond_ready), 32'd1);
        chk({tag, "_valid"}, 32'(i0.cond_valid), 32'd0);
        chk({tag, "_true"},  32'(i0.cond_true),  32'd0);
        chk({tag, "_valid2"}, 32'(i2.cond_valid), 32'd0);
        chk({tag, "_state"}, 32'(i0.dbg_state),  32'd0);
        chk_counts(tag);
        chk_psr(tag);
    endtask

    task automatic bump(input bit t0, input bit t1, input bit t2);
        if (t0) cnt0++;
        if (t1) cnt1++;
        if (t2 && cnt2 < 3) cnt2++;
    endtask

    // One full request/response/ack transaction; all instances expect the same result
    task automatic do_eval(input string tag, input logic [3:0] code, input bit exp);
        cond_req = 1'b1;
        cond_code = code;
        cyc();
        cond_req = 1'b0;
        cond_code = 4'h0;
        bump(exp, exp, exp);
        chk({tag, "_valid"}, 32'(i0.cond_valid), 32'd1);
        chk({tag, "_ready"}, 32'(i0.cond_ready), 32'd0);
        chk({tag, "_true0"}, 32'(i0.cond_true), 32'(exp));
        chk({tag, "_true1"}, 32'(i1.cond_true), 32'(exp));
        chk({tag, "_true2"}, 32'(i2.cond_true), 32'(exp));
        chk_counts(tag);
        cond_ack = 1'b1;
        cyc();
        cond_ack = 1'b0;
        chk({tag, "_ack_ready"}, 32'(i0.cond_ready), 32'd1);
        chk({tag, "_ack_valid"}, 32'(i1.cond_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cnt0 = 0; cnt1 = 0; cnt2 = 0; exp_psr = 16'h0000;
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        int exp_set [16] = '{1,0,1,0,1,0,1,0,1,0,0,1,0,1,1,0};
        int exp_clr [16] = '{0,1,0,1,0,1,0,1,0,1,1,0,1,0,1,0};
        total = 0; bad = 0;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; exp_psr = 16'h0000;
        reset = 1'b1;
        alu_flags = '0; flag_we_cf = 0; flag_we_lnz = 0; psr_wr = 0; psr_wdata = '0;
        cond_req = 0; cond_ack = 0; cond_code = '0;

        // reset state
        #12;
        chk_idle_reset("reset");
        @(negedge clk);
        reset = 1'b0;
        cyc();

        // 1: Z load via flag_we_lnz, then EQ / NE
        flag_we_lnz = 1'b1; alu_flags = 16'h0040;
        cyc();
        flag_we_lnz = 1'b0; alu_flags = 16'h0000;
        exp_psr = 16'h0040;
        chk_psr("lnz_load");
        do_eval("t1_eq", 4'b0000, 1'b1);
        do_eval("t1_ne", 4'b0001, 1'b0);

        // flag_we_cf only touches C and F
        flag_we_cf = 1'b1; alu_flags = 16'hFFFF;
        cyc();
        flag_we_cf = 1'b0; alu_flags = 16'h0000;
        exp_psr = 16'h0061;
        chk_psr("cf_load");

        // 2: psr_wr beats flag_we_cf, reserved bits masked
        psr_wr = 1'b1; psr_wdata = 16'hFFFF; flag_we_cf = 1'b1; alu_flags = 16'h0000;
        cyc();
        psr_wr = 1'b0; flag_we_cf = 1'b0;
        exp_psr = 16'h00E5;
        chk_psr("wr_prio");

        // 3: sweep all codes with psr=00E5 and psr=0
        for (int c = 0; c < 16; c++) do_eval($sformatf("sweep_set_%0d", c), 4'(c), exp_set[c][0]);
        psr_wr = 1'b1; psr_wdata = 16'h0000;
        cyc();
        psr_wr = 1'b0;
        exp_psr = 16'h0000;
        chk_psr("clr");
        for (int c = 0; c < 16; c++) do_eval($sformatf("sweep_clr_%0d", c), 4'(c), exp_clr[c][0]);

        // 4: EQ requested in the same cycle Z is loaded; only bypass sees it
        cond_req = 1'b1; cond_code = 4'b0000; flag_we_lnz = 1'b1; alu_flags = 16'h0040;
        cyc();
        cond_req = 1'b0; flag_we_lnz = 1'b0; alu_flags = 16'h0000;
        exp_psr = 16'h0040;
        bump(1'b0, 1'b1, 1'b0);
        chk("byp_true0", 32'(i0.cond_true), 32'd0);
        chk("byp_true1", 32'(i1.cond_true), 32'd1);
        chk("byp_true2", 32'(i2.cond_true), 32'd0);
        chk_psr("byp");
        chk_counts("byp");
        cond_ack = 1'b1;
        cyc();
        cond_ack = 1'b0;

        // ack while idle does nothing
        cond_ack = 1'b1;
        cyc();
        cond_ack = 1'b0;
        chk("idle_ack_ready", 32'(i0.cond_ready), 32'd1);
        chk("idle_ack_valid", 32'(i0.cond_valid), 32'd0);

        // 5: hold response for 5 cycles while req and PSR writes toggle
        cond_req = 1'b1; cond_code = 4'b0000;
        cyc();
        bump(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cond_req = (i % 2 == 0);
            cond_code = 4'b1111;
            psr_wr = 1'b1;
            psr_wdata = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
            cyc();
            exp_psr = (i % 2 == 1) ? 16'h00E5 : 16'h0000;
            chk($sformatf("hold%0d_valid", i), 32'(i0.cond_valid), 32'd1);
            chk($sformatf("hold%0d_ready", i), 32'(i0.cond_ready), 32'd0);
            chk($sformatf("hold%0d_true0", i), 32'(i0.cond_true), 32'd1);
            chk($sformatf("hold%0d_true1", i), 32'(i1.cond_true), 32'd1);
            chk_psr($sformatf("hold%0d", i));
            chk_counts($sformatf("hold%0d", i));
        end
        psr_wr = 1'b0;
        // ack with a request pending: return to IDLE, no same-cycle accept
        cond_req = 1'b1; cond_code = 4'b1110; cond_ack = 1'b1;
        cyc();
        cond_req = 1'b0; cond_ack = 1'b0;
        chk("noshort_ready", 32'(i0.cond_ready), 32'd1);
        chk("noshort_valid", 32'(i0.cond_valid), 32'd0);
        chk("noshort_true", 32'(i0.cond_true), 32'd1);
        chk_counts("noshort");

        // 6: counter saturation from a fresh reset
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_eval($sformatf("sat%0d", k), 4'b1110, 1'b1);
            chk($sformatf("sat%0d_abs", k), 32'(i2.taken_count), (k < 3) ? 32'(k + 1) : 32'd3);
        end

        // reset in RESP clears outputs without a clock edge
        psr_wr = 1'b1; psr_wdata = 16'h00FF;
        cyc();
        psr_wr = 1'b0;
        cond_req = 1'b1; cond_code = 4'b1110;
        cyc();
        cond_req = 1'b0;
        chk("pre_rst_valid", 32'(i0.cond_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        cnt0 = 0; cnt1 = 0; cnt2 = 0; exp_psr = 16'h0000;
        chk_idle_reset("async_rst");
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("post_rst_ready", 32'(i0.cond_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
